// File: rtl/fft_bfly_sched_pkg.sv
// Shared constants and state encoding for the 8-point radix-2 DIT butterfly scheduler.
package fft_bfly_sched_pkg;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int NBF   = 4;
  localparam int NSTG  = 3;

  typedef logic [1:0] sched_st_t;

  localparam sched_st_t S_IDLE  = 2'd0;
  localparam sched_st_t S_ISSUE = 2'd1;
  localparam sched_st_t S_DRAIN = 2'd2;
  localparam sched_st_t S_DONE  = 2'd3;

endpackage

// File: rtl/fft_bfly_sched_if.sv
// Control/issue/writeback bundle between the top-level control, the scheduler and the butterfly path.
interface fft_bfly_sched_if;
  import fft_bfly_sched_pkg::*;

  logic             start;
  logic             en;
  logic             wb_v;
  logic             bf_v;
  logic [LOG2N-1:0] bf_a;
  logic [LOG2N-1:0] bf_b;
  logic [1:0]       tw_idx;
  logic [1:0]       stage;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, en, wb_v,
    input  bf_v, bf_a, bf_b, tw_idx, stage, busy, done, err
  );

  modport slave (
    input  start, en, wb_v,
    output bf_v, bf_a, bf_b, tw_idx, stage, busy, done, err
  );

endinterface

// File: rtl/fft_bfly_sched_addr_gen.sv
// Maps (stage, butterfly index) to the in-place read pair and twiddle exponent of W8^k.
module fft_addr_gen
  import fft_bfly_sched_pkg::*;
(
  input  logic [1:0]       stage,
  input  logic [1:0]       bf_cnt,
  output logic [LOG2N-1:0] bf_a,
  output logic [LOG2N-1:0] bf_b,
  output logic [1:0]       tw_idx
);

  logic [2:0] span;
  logic [2:0] grp;
  logic [2:0] j;
  logic [2:0] tw_full;

  // Group base is grp*2*span; j walks within the group, and twiddles spread as j scaled to N/2.
  always_comb begin
    span    = 3'd1 << stage;
    grp     = {1'b0, bf_cnt} >> stage;
    j       = {1'b0, bf_cnt} & (span - 3'd1);
    bf_a    = (grp << (stage + 2'd1)) + j;
    bf_b    = bf_a + span;
    tw_full = j << (2'd2 - stage);
    tw_idx  = tw_full[1:0];
  end

endmodule

// File: rtl/fft_bfly_sched.sv
// Butterfly scheduler: issues 3 stages x 4 butterflies and holds each stage until all writebacks land.
module fft_bfly_sched
  import fft_bfly_sched_pkg::*;
#(
  parameter int LAT = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  fft_bfly_sched_if.slave  bus
);

  if (LAT < 1) begin : g_lat_check
    $error("fft_bfly_sched: LAT must be >= 1");
  end

  sched_st_t        state;
  logic [1:0]       stage;
  logic [1:0]       bf_cnt;
  logic [2:0]       wb_cnt;
  logic             err;

  logic             last_bf;
  logic             last_stage;
  logic             wb_full;
  logic             in_busy;
  logic [LOG2N-1:0] gen_a;
  logic [LOG2N-1:0] gen_b;
  logic [1:0]       gen_tw;

  assign last_bf    = (bf_cnt == 2'(NBF - 1));
  assign last_stage = (stage == 2'(NSTG - 1));
  assign wb_full    = (wb_cnt == 3'(NBF));
  assign in_busy    = (state == S_ISSUE) || (state == S_DRAIN);

  fft_addr_gen u_addr_gen (
    .stage  (stage),
    .bf_cnt (bf_cnt),
    .bf_a   (gen_a),
    .bf_b   (gen_b),
    .tw_idx (gen_tw)
  );

  // Writebacks are counted in ISSUE too, so a short pipeline can return results before the last issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      stage  <= 2'd0;
      bf_cnt <= 2'd0;
      wb_cnt <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_ISSUE;
            stage  <= 2'd0;
            bf_cnt <= 2'd0;
            wb_cnt <= 3'd0;
          end
        end
        S_ISSUE: begin
          if (bus.en) begin
            bf_cnt <= bf_cnt + 2'd1;
            if (last_bf) begin
              state <= S_DRAIN;
            end
          end
          if (bus.wb_v && !wb_full) begin
            wb_cnt <= wb_cnt + 3'd1;
          end
        end
        S_DRAIN: begin
          if (wb_full) begin
            if (last_stage) begin
              state <= S_DONE;
            end else begin
              state  <= S_ISSUE;
              stage  <= stage + 2'd1;
              bf_cnt <= 2'd0;
              wb_cnt <= 3'd0;
            end
          end else if (bus.wb_v) begin
            wb_cnt <= wb_cnt + 3'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          stage <= 2'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // An accepted start clears err; a writeback nobody is waiting for sets it and it sticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((state == S_IDLE) && bus.start) begin
      err <= 1'b0;
    end else if (bus.wb_v && ((state == S_IDLE) || (state == S_DONE) || wb_full)) begin
      err <= 1'b1;
    end
  end

  assign bus.bf_v   = (state == S_ISSUE) && bus.en;
  assign bus.busy   = in_busy;
  assign bus.done   = (state == S_DONE);
  assign bus.err    = err;
  assign bus.stage  = stage;
  assign bus.bf_a   = in_busy ? gen_a  : '0;
  assign bus.bf_b   = in_busy ? gen_b  : '0;
  assign bus.tw_idx = in_busy ? gen_tw : 2'd0;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Bench for fft_bfly_sched: models the address delay line and checks every cycle against a stage/count model.
module tb_fft_bfly_sched;
  import fft_bfly_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_bfly_sched_if bus7();
  fft_bfly_sched_if bus1();

  fft_bfly_sched #(.LAT(7)) u_dut7 (.clk(clk), .rst_n(rst_n), .bus(bus7.slave));
  fft_bfly_sched #(.LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  logic sel1 = 1'b0;
  logic start_d = 1'b0;
  logic en_d = 1'b0;
  logic wbv_d = 1'b0;

  assign bus7.start = !sel1 && start_d;
  assign bus7.en    = en_d;
  assign bus7.wb_v  = !sel1 && wbv_d;
  assign bus1.start = sel1 && start_d;
  assign bus1.en    = en_d;
  assign bus1.wb_v  = sel1 && wbv_d;

  logic       o_bfv, o_busy, o_done, o_err;
  logic [2:0] o_a, o_b;
  logic [1:0] o_tw, o_stage;

  always_comb begin
    if (sel1) begin
      o_bfv = bus1.bf_v; o_busy = bus1.busy; o_done = bus1.done; o_err = bus1.err;
      o_a = bus1.bf_a; o_b = bus1.bf_b; o_tw = bus1.tw_idx; o_stage = bus1.stage;
    end else begin
      o_bfv = bus7.bf_v; o_busy = bus7.busy; o_done = bus7.done; o_err = bus7.err;
      o_a = bus7.bf_a; o_b = bus7.bf_b; o_tw = bus7.tw_idx; o_stage = bus7.stage;
    end
  end

  // Expected butterfly table: per stage, the four read pairs and twiddle exponents in issue order.
  int ref_a  [0:2][0:3] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
  int ref_b  [0:2][0:3] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
  int ref_tw [0:2][0:3] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

  int vectors = 0;
  int miscompares = 0;

  // Model: 0 idle, 1 issuing, 2 waiting for results, 3 done pulse.
  int m_mode = 0, m_stage = 0, m_k = 0, m_ret = 0;
  bit m_err = 1'b0;

  int start0_cyc, start2_cyc, start3_cyc, stall_lo, stall_hi, delay_n, delay_x, inject_cyc, rst_cyc, lat;
  bit rand_en, rand_lat;

  int cyc, issue_no, done_cyc, err_cyc;
  logic done_err;
  int due[$];
  int issue_cyc[$];
  int issue_a[$];
  logic [13:0] obs_vec, exp_vec;

  task automatic init_run(input logic use_lat1);
    sel1 = use_lat1;
    lat = use_lat1 ? 1 : 7;
    start0_cyc = 0; start2_cyc = -1; start3_cyc = -1;
    stall_lo = -1; stall_hi = -1; delay_n = -1; delay_x = 0;
    inject_cyc = -1; rst_cyc = -1; rand_en = 1'b0; rand_lat = 1'b0;
    cyc = 0; issue_no = 0; done_cyc = -1; err_cyc = -1; done_err = 1'bx;
    due.delete(); issue_cyc.delete(); issue_a.delete();
  endtask

  task automatic tick();
    int pick;
    int old_ret;
    logic e_bfv, e_busy, e_done;
    logic [1:0] e_stage;
    logic [7:0] e_addr;
    start_d = (cyc == start0_cyc) || (cyc == start2_cyc) || (cyc == start3_cyc);
    en_d = !(cyc >= stall_lo && cyc <= stall_hi);
    if (rand_en && $urandom_range(0, 3) == 0) en_d = 1'b0;
    wbv_d = 1'b0;
    if (cyc == inject_cyc) begin
      wbv_d = 1'b1;
    end else begin
      pick = -1;
      foreach (due[i]) if (due[i] <= cyc && (pick < 0 || due[i] < due[pick])) pick = i;
      if (pick >= 0) begin
        wbv_d = 1'b1;
        due.delete(pick);
      end
    end
    rst_n = (cyc == rst_cyc) ? 1'b0 : 1'b1;
    #3;
    obs_vec = {o_bfv, o_busy, o_done, o_err, (o_busy ? o_stage : 2'd0), (o_bfv ? {o_a, o_b, o_tw} : 8'd0)};
    e_busy = (m_mode == 1) || (m_mode == 2);
    e_bfv = (m_mode == 1) && en_d;
    e_done = (m_mode == 3);
    e_stage = e_busy ? m_stage[1:0] : 2'd0;
    e_addr = 8'd0;
    if (e_bfv) e_addr = {3'(ref_a[m_stage][m_k]), 3'(ref_b[m_stage][m_k]), 2'(ref_tw[m_stage][m_k])};
    exp_vec = {e_bfv, e_busy, e_done, m_err, e_stage, e_addr};
    if (o_bfv === 1'b1) begin
      issue_cyc.push_back(cyc);
      issue_a.push_back(int'(o_a));
      due.push_back(cyc + lat + ((issue_no == delay_n) ? delay_x : 0) + (rand_lat ? int'($urandom_range(0, 3)) : 0));
      issue_no++;
    end
    if (o_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
    if (o_done === 1'b1 && done_cyc < 0) begin
      done_cyc = cyc;
      done_err = o_err;
    end
    if (!rst_n) begin
      m_mode = 0; m_stage = 0; m_k = 0; m_ret = 0; m_err = 1'b0;
      due.delete();
    end else begin
      case (m_mode)
        0: begin
          if (wbv_d) m_err = 1'b1;
          if (start_d) begin
            m_mode = 1; m_stage = 0; m_k = 0; m_ret = 0; m_err = 1'b0;
          end
        end
        1: begin
          if (wbv_d) begin
            if (m_ret == 4) m_err = 1'b1; else m_ret++;
          end
          if (en_d) begin
            m_k++;
            if (m_k == 4) m_mode = 2;
          end
        end
        2: begin
          old_ret = m_ret;
          if (wbv_d) begin
            if (old_ret == 4) m_err = 1'b1; else m_ret++;
          end
          if (old_ret == 4) begin
            if (m_stage == 2) m_mode = 3;
            else begin
              m_mode = 1; m_stage++; m_k = 0; m_ret = 0;
            end
          end
        end
        default: begin
          if (wbv_d) m_err = 1'b1;
          m_mode = 0;
        end
      endcase
    end
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic test_reset();
    init_run(1'b0);
    start0_cyc = -1;
    rst_cyc = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c > 0) begin
        vectors++;
        if ({o_bfv, o_busy, o_done, o_err, o_stage, o_a, o_b, o_tw} !== 14'd0) begin
          miscompares++;
          $display("[TB] FAIL reset_outputs cyc %0d: got %h want 0", cyc - 1, {o_bfv, o_busy, o_done, o_err, o_stage, o_a, o_b, o_tw});
        end
      end
    end
  endtask

  task automatic test_nominal();
    init_run(1'b0);
    for (int c = 0; c < 45; c++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL nominal cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (done_cyc !== 37) begin
      miscompares++;
      $display("[TB] FAIL nominal_done_cycle: got %0d want 37", done_cyc);
    end
    vectors++;
    if (issue_cyc.size() != 12 || issue_cyc[4] != 13 || issue_cyc[8] != 25) begin
      miscompares++;
      $display("[TB] FAIL nominal_issue_cycles: got n=%0d", issue_cyc.size());
    end
  endtask

  task automatic test_stall();
    init_run(1'b0);
    stall_lo = 2;
    stall_hi = 4;
    for (int c = 0; c < 48; c++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL stall cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (issue_cyc.size() != 12 || issue_cyc[1] != 5 || issue_cyc[2] != 6 || issue_cyc[3] != 7
        || issue_a[1] != 2 || issue_a[2] != 4 || issue_a[3] != 6) begin
      miscompares++;
      $display("[TB] FAIL stall_issue_slots: got n=%0d want pairs at cycles 5,6,7", issue_cyc.size());
    end
    vectors++;
    if (done_cyc !== 40) begin
      miscompares++;
      $display("[TB] FAIL stall_done_cycle: got %0d want 40", done_cyc);
    end
  endtask

  task automatic test_drain_hold();
    init_run(1'b0);
    delay_n = 3;
    delay_x = 10;
    for (int c = 0; c < 55; c++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL drain_hold cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (issue_cyc.size() != 12 || issue_cyc[4] != 23) begin
      miscompares++;
      $display("[TB] FAIL drain_hold_stage1_start: got n=%0d want stage 1 at cycle 23", issue_cyc.size());
    end
    vectors++;
    if (done_cyc !== 47) begin
      miscompares++;
      $display("[TB] FAIL drain_hold_done_cycle: got %0d want 47", done_cyc);
    end
  endtask

  task automatic test_protocol_err();
    init_run(1'b0);
    inject_cyc = 18;
    for (int c = 0; c < 42; c++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL err_extra_wb cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (err_cyc !== 24 || done_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL err_sticky: got rise %0d err@done %b want rise 24 err@done 1", err_cyc, done_err);
    end
    init_run(1'b0);
    for (int c = 0; c < 42; c++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL err_clear cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (err_cyc !== 0 || done_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_clear_on_start: got last-high %0d err@done %b want 0 and 0", err_cyc, done_err);
    end
    init_run(1'b0);
    start0_cyc = -1;
    inject_cyc = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL err_idle_wb cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (err_cyc !== 2) begin
      miscompares++;
      $display("[TB] FAIL err_idle_rise: got %0d want 2", err_cyc);
    end
  endtask

  task automatic test_start_edges();
    init_run(1'b0);
    start2_cyc = 20;
    start3_cyc = 37;
    for (int c = 0; c < 45; c++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL start_ignored cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (done_cyc !== 37 || issue_cyc.size() != 12) begin
      miscompares++;
      $display("[TB] FAIL start_ignored_summary: got done %0d issues %0d want 37 and 12", done_cyc, issue_cyc.size());
    end
    init_run(1'b0);
    rst_cyc = 10;
    for (int c = 0; c < 16; c++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL reset_abort cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec);
      end
      if (c == 11) begin
        vectors++;
        if ({o_bfv, o_busy, o_done, o_err, o_stage, o_a, o_b, o_tw} !== 14'd0) begin
          miscompares++;
          $display("[TB] FAIL reset_abort_zero: got %h want 0", {o_bfv, o_busy, o_done, o_err, o_stage, o_a, o_b, o_tw});
        end
      end
    end
  endtask

  task automatic test_lat1();
    init_run(1'b1);
    for (int c = 0; c < 25; c++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL lat1 cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (done_cyc !== 19) begin
      miscompares++;
      $display("[TB] FAIL lat1_done_cycle: got %0d want 19", done_cyc);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      init_run(logic'($urandom_range(0, 1)));
      rand_en = 1'b1;
      rand_lat = 1'b1;
      for (int c = 0; c < 200; c++) begin
        tick();
        vectors++;
        if (obs_vec !== exp_vec) begin
          miscompares++;
          $display("[TB] FAIL random run %0d cyc %0d: got %h want %h", r, cyc - 1, obs_vec, exp_vec);
        end
      end
      vectors++;
      if (done_cyc < 0 || issue_cyc.size() != 12) begin
        miscompares++;
        $display("[TB] FAIL random_complete run %0d: got done %0d issues %0d want done seen and 12", r, done_cyc, issue_cyc.size());
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    @(posedge clk);
    #2;
    test_reset();
    test_nominal();
    test_stall();
    test_drain_hold();
    test_protocol_err();
    test_start_edges();
    test_lat1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
